// File: rtl/sync_frame_sequencer_if.sv
// Bus bundle between the frame sequencer and its controller: config/sync in, strobes/status out.
interface sync_frame_sequencer_if #(
    parameter int unsigned NCH = 4
);
    logic           sync;
    logic           enable;
    logic [NCH-1:0] ch_mask;
    logic [15:0]    fire_delay;
    logic [15:0]    acq_len;
    logic           clr_overrun;
    logic [NCH-1:0] fire;
    logic           acq;
    logic [3:0]     ch_idx;
    logic           busy;
    logic           frame_done;
    logic           aborted;
    logic [15:0]    overrun_cnt;

    modport slave (
        input  sync, enable, ch_mask, fire_delay, acq_len, clr_overrun,
        output fire, acq, ch_idx, busy, frame_done, aborted, overrun_cnt
    );

    modport master (
        output sync, enable, ch_mask, fire_delay, acq_len, clr_overrun,
        input  fire, acq, ch_idx, busy, frame_done, aborted, overrun_cnt
    );
endinterface

// File: rtl/sync_frame_sequencer.sv
// Per-sync acquisition frame: for each enabled channel in ascending order,
// wait the fire delay, strobe fire for one cycle, then hold the acquisition window.
module sync_frame_sequencer #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned CLK_PER_US = 100
) (
    input  logic                       clk,
    input  logic                       rst_n,
    sync_frame_sequencer_if.slave      bus
);
    localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [NCH-1:0] ONE_HOT0 = NCH'(1);

    typedef enum logic [2:0] {IDLE, DELAY, FIRE, ACQ, NEXT} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  pre_q, pre_d;
    logic [15:0]    us_q, us_d;
    logic [3:0]     ch_q, ch_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [15:0]    dly_q, dly_d;
    logic [15:0]    alen_q, alen_d;
    logic [NCH-1:0] fire_q, fire_d;
    logic           acq_q, acq_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           aborted_q, aborted_d;
    logic [15:0]    ovr_q, ovr_d;

    logic           tick;
    logic           ovr_evt;
    logic [4:0]     first_bit;
    logic [4:0]     next_bit;

    // Lowest set bit of m at index >= lo; bit 4 set means none found.
    function automatic logic [4:0] find_bit(input logic [NCH-1:0] m, input logic [4:0] lo);
        logic [4:0] r;
        r = 5'd16;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && (5'(i) >= lo)) r = 5'(i);
        end
        return r;
    endfunction

    always_comb begin
        tick      = (pre_q == PW'(CLK_PER_US - 1));
        ovr_evt   = bus.sync && (state_q != IDLE);
        first_bit = find_bit(bus.ch_mask, 5'd0);
        next_bit  = find_bit(mask_q, 5'(ch_q) + 5'd1);

        state_d   = state_q;
        ch_d      = ch_q;
        mask_d    = mask_q;
        dly_d     = dly_q;
        alen_d    = alen_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        ovr_d     = ovr_q;
        pre_d     = tick ? '0 : pre_q + PW'(1);
        us_d      = tick ? us_q + 16'd1 : us_q;

        case (state_q)
            IDLE: begin
                pre_d = '0;
                us_d  = '0;
                if (bus.sync && bus.enable && (bus.ch_mask != '0)) begin
                    mask_d  = bus.ch_mask;
                    dly_d   = bus.fire_delay;
                    alen_d  = (bus.acq_len == 16'd0) ? 16'd1 : bus.acq_len;
                    ch_d    = first_bit[3:0];
                    state_d = (bus.fire_delay == 16'd0) ? FIRE : DELAY;
                end
            end
            DELAY: begin
                if (tick && (us_q == dly_q - 16'd1)) state_d = FIRE;
            end
            FIRE: begin
                pre_d   = '0;
                us_d    = '0;
                state_d = ACQ;
            end
            ACQ: begin
                if (tick && (us_q == alen_q - 16'd1)) begin
                    state_d = NEXT;
                    done_d  = next_bit[4];
                end
            end
            NEXT: begin
                if (!next_bit[4]) begin
                    ch_d    = next_bit[3:0];
                    pre_d   = '0;
                    us_d    = '0;
                    state_d = (dly_q == 16'd0) ? FIRE : DELAY;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Enable low kills any frame in progress without a done pulse.
        if ((state_q != IDLE) && !bus.enable) begin
            state_d   = IDLE;
            ch_d      = ch_q;
            done_d    = 1'b0;
            aborted_d = 1'b1;
        end

        if (bus.clr_overrun) ovr_d = ovr_evt ? 16'd1 : 16'd0;
        else if (ovr_evt && (ovr_q != 16'hFFFF)) ovr_d = ovr_q + 16'd1;

        fire_d = (state_d == FIRE) ? (ONE_HOT0 << ch_d) : '0;
        acq_d  = (state_d == ACQ);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            us_q      <= '0;
            ch_q      <= '0;
            mask_q    <= '0;
            dly_q     <= '0;
            alen_q    <= '0;
            fire_q    <= '0;
            acq_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            ovr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            us_q      <= us_d;
            ch_q      <= ch_d;
            mask_q    <= mask_d;
            dly_q     <= dly_d;
            alen_q    <= alen_d;
            fire_q    <= fire_d;
            acq_q     <= acq_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            ovr_q     <= ovr_d;
        end
    end

    assign bus.fire        = fire_q;
    assign bus.acq         = acq_q;
    assign bus.ch_idx      = ch_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = done_q;
    assign bus.aborted     = aborted_q;
    assign bus.overrun_cnt = ovr_q;
endmodule
